// File: rtl/snax_simbacore_launch_pkg.sv
// Shared types for the SimbaCore job launcher: FSM states, the config-set struct,
// word positions inside the flat CSR vector and pack/unpack helpers.
package snax_simbacore_launch_pkg;

  localparam int unsigned REG_DATA_WIDTH = 32;
  localparam int unsigned CFG_WORDS      = 6;
  localparam int unsigned CFG_WIDTH      = REG_DATA_WIDTH * CFG_WORDS;

  localparam int unsigned W_MODE    = 0;
  localparam int unsigned W_SEQ_LEN = 1;
  localparam int unsigned W_D_MODEL = 2;
  localparam int unsigned W_DT_RANK = 3;
  localparam int unsigned W_D_INNER = 4;
  localparam int unsigned W_D_FINAL = 5;

  typedef logic [REG_DATA_WIDTH-1:0] reg_word_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RUN
  } launch_state_e;

  typedef struct packed {
    reg_word_t mode;
    reg_word_t seq_len;
    reg_word_t d_model;
    reg_word_t dt_rank;
    reg_word_t d_inner;
    reg_word_t d_final;
  } simbacore_cfg_t;

  // Word 0 sits in the least significant bits of the flat CSR vector.
  function automatic simbacore_cfg_t unpack_cfg(input logic [CFG_WIDTH-1:0] flat);
    simbacore_cfg_t c;
    c.mode    = flat[W_MODE    * REG_DATA_WIDTH +: REG_DATA_WIDTH];
    c.seq_len = flat[W_SEQ_LEN * REG_DATA_WIDTH +: REG_DATA_WIDTH];
    c.d_model = flat[W_D_MODEL * REG_DATA_WIDTH +: REG_DATA_WIDTH];
    c.dt_rank = flat[W_DT_RANK * REG_DATA_WIDTH +: REG_DATA_WIDTH];
    c.d_inner = flat[W_D_INNER * REG_DATA_WIDTH +: REG_DATA_WIDTH];
    c.d_final = flat[W_D_FINAL * REG_DATA_WIDTH +: REG_DATA_WIDTH];
    return c;
  endfunction

  function automatic logic [CFG_WIDTH-1:0] pack_cfg(input simbacore_cfg_t c);
    logic [CFG_WIDTH-1:0] flat;
    flat = '0;
    flat[W_MODE    * REG_DATA_WIDTH +: REG_DATA_WIDTH] = c.mode;
    flat[W_SEQ_LEN * REG_DATA_WIDTH +: REG_DATA_WIDTH] = c.seq_len;
    flat[W_D_MODEL * REG_DATA_WIDTH +: REG_DATA_WIDTH] = c.d_model;
    flat[W_DT_RANK * REG_DATA_WIDTH +: REG_DATA_WIDTH] = c.dt_rank;
    flat[W_D_INNER * REG_DATA_WIDTH +: REG_DATA_WIDTH] = c.d_inner;
    flat[W_D_FINAL * REG_DATA_WIDTH +: REG_DATA_WIDTH] = c.d_final;
    return flat;
  endfunction

endpackage

// File: rtl/snax_simbacore_cfg_fifo.sv
// Register FIFO holding complete SimbaCore config sets; no fall-through, no bypass.
// Depth must be a power of two so the pointers wrap naturally.
module snax_simbacore_cfg_fifo
  import snax_simbacore_launch_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  simbacore_cfg_t           wdata,
  output simbacore_cfg_t           rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);

  localparam int unsigned PtrWidth = $clog2(Depth);
  localparam int unsigned CntWidth = PtrWidth + 1;

  simbacore_cfg_t      mem [Depth];
  logic [PtrWidth-1:0] wr_ptr;
  logic [PtrWidth-1:0] rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign full    = (count == CntWidth'(Depth));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PtrWidth'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PtrWidth'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CntWidth'(1);
        2'b01:   count <= count - CntWidth'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only read after count shows it was written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/snax_simbacore_launch_ctrl.sv
// Queues CSR config sets and launches them on SimbaCore one job at a time.
// Define SNAX_SIMBACORE_LAUNCH_PERF_EN to build the per-job cycle counter.
module snax_simbacore_launch_ctrl
  import snax_simbacore_launch_pkg::*;
#(
  parameter int unsigned RegDataWidth = REG_DATA_WIDTH,
  parameter int unsigned CfgWords     = CFG_WORDS,
  parameter int unsigned ModeWidth    = 13,
  parameter int unsigned QueueDepth   = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [CfgWords*RegDataWidth-1:0] cfg_i,
  input  logic                             cfg_valid_i,
  output logic                             cfg_ready_o,
  output logic [CfgWords*RegDataWidth-1:0] core_cfg_o,
  output logic                             core_cfg_valid_o,
  input  logic                             core_cfg_ready_i,
  input  logic                             core_busy_i,
  output logic                             busy_o,
  output logic [$clog2(QueueDepth):0]      pending_o,
  output logic [RegDataWidth-1:0]          jobs_done_o,
  output logic [RegDataWidth-1:0]          last_cycles_o
);

  localparam reg_word_t MODE_MASK = reg_word_t'((64'd1 << ModeWidth) - 64'd1);

  launch_state_e           state;
  logic                    first;
  logic [RegDataWidth-1:0] jobs_done;
  simbacore_cfg_t          head;
  simbacore_cfg_t          issue_cfg;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    accept;
  logic                    complete;

  assign accept   = (state == ISSUE) && core_cfg_ready_i;
  assign complete = (state == RUN) && !first && !core_busy_i;

  snax_simbacore_cfg_fifo #(
    .Depth (QueueDepth)
  ) u_cfg_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (cfg_valid_i),
    .pop   (accept),
    .wdata (unpack_cfg(cfg_i)),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (pending_o)
  );

  // Data is only driven while issuing so the idle bus reads as zero.
  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    issue_cfg      = head;
    issue_cfg.mode = head.mode & MODE_MASK;
    core_cfg_o     = '0;
    if (state == ISSUE) core_cfg_o = pack_cfg(issue_cfg);
  end

  assign core_cfg_valid_o = (state == ISSUE);
  assign cfg_ready_o      = !fifo_full;
  assign busy_o           = (state != IDLE) || !fifo_empty;
  assign jobs_done_o      = jobs_done;

  // SimbaCore may still show the previous job's busy in the first RUN cycle, hence the first flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      first     <= 1'b0;
      jobs_done <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!fifo_empty) state <= ISSUE;
        end
        ISSUE: begin
          if (core_cfg_ready_i) begin
            state <= RUN;
            first <= 1'b1;
          end
        end
        RUN: begin
          if (first) begin
            first <= 1'b0;
          end else if (!core_busy_i) begin
            jobs_done <= jobs_done + RegDataWidth'(1);
            state     <= fifo_empty ? IDLE : ISSUE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SNAX_SIMBACORE_LAUNCH_PERF_EN
  logic [RegDataWidth-1:0] cycle_cnt;
  logic [RegDataWidth-1:0] cycle_next;
  logic [RegDataWidth-1:0] last_cycles;

  // Saturating increment: a runaway job reads as all-ones rather than wrapping to a small value.
  assign cycle_next = (cycle_cnt == {RegDataWidth{1'b1}}) ? cycle_cnt
                                                          : cycle_cnt + RegDataWidth'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cycle_cnt   <= '0;
      last_cycles <= '0;
    end else begin
      if (accept) begin
        cycle_cnt <= '0;
      end else if (state == RUN) begin
        cycle_cnt <= cycle_next;
      end
      if (complete) last_cycles <= cycle_next;
    end
  end

  assign last_cycles_o = last_cycles;
`else
  assign last_cycles_o = '0;
`endif

endmodule

// File: doc/snax_simbacore_launch_ctrl.md
# snax_simbacore_launch_ctrl

Job launcher between the SNAX CSR manager and the SimbaCore config port. It buffers up to `QueueDepth` complete configuration sets written by the core. It issues them to SimbaCore one at a time over a valid/ready handshake, tracks each job until the core's busy flag falls, and exposes aggregate status and a per-job cycle count to the read-only CSRs.

## Interface
- `RegDataWidth`, 32: width of one CSR word.
- `CfgWords`, 6: words per job, in order: mode, seqLen, dModel, dtRank, dInner, dFinal.
- `ModeWidth`, 13: valid bits of word 0; upper bits are forced to zero on issue.
- `QueueDepth`, 2: pending-job FIFO depth; power of two, ≥2.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  asynchronous reset, active-high.
- `cfg_i`  in  CfgWords×RegDataWidth  job config from CSR manager.
- `cfg_valid_i`  in  1  config valid.
- `cfg_ready_o`  out  1  FIFO not full.
- `core_cfg_o`  out  CfgWords×RegDataWidth  FIFO head, mode masked to ModeWidth.
- `core_cfg_valid_o`  out  1  issue request to SimbaCore.
- `core_cfg_ready_i`  in  1  SimbaCore accepts config.
- `core_busy_i`  in  1  SimbaCore busy.
- `busy_o`  out  1  job running or pending.
- `pending_o`  out  $clog2(QueueDepth)+1  FIFO occupancy.
- `jobs_done_o`  out  RegDataWidth  completed-job count.
- `last_cycles_o`  out  RegDataWidth  cycles of last completed job.

## Operation
- **FIFO**
  - Push when `cfg_valid_i && cfg_ready_o`.
  - `cfg_ready_o = !full`; there is no bypass when full, even if a pop happens in the same cycle.
  - Pushing into an empty FIFO makes the entry visible the next cycle; there is no fall-through.
  - Simultaneous push and pop keeps occupancy unchanged.
- **FSM states: IDLE, ISSUE, RUN.**
  - IDLE: go to ISSUE when the FIFO is non-empty.
  - ISSUE: `core_cfg_valid_o=1`, `core_cfg_o` = head. On `core_cfg_ready_i`, pop the FIFO, clear the cycle counter, set `first`, and go to RUN. Valid and data stay stable until accepted.
  - RUN:
    - The cycle counter increments every cycle.
    - In the first RUN cycle (`first`=1), `core_busy_i` is ignored and `first` clears.
    - Afterwards, `core_busy_i==0` completes the job: `jobs_done_o`+1 (wraps modulo 2^RegDataWidth), and `last_cycles_o` ← counter+1.
    - On completion, go to ISSUE if the FIFO is non-empty, else IDLE.
- `busy_o = (state!=IDLE) || !empty`.
- **Arithmetic**
  - The cycle counter is RegDataWidth bits and saturates at all-ones; it does not wrap.
  - `pending_o` counts 0..QueueDepth inclusive.
- **Reset mid-job:** all state clears asynchronously. SimbaCore itself is not reset by this block.

## Timing
- Reset values:
  - `cfg_ready_o=1`
  - `core_cfg_valid_o=0`
  - `core_cfg_o=0`
  - `busy_o=0`
  - `pending_o=0`
  - `jobs_done_o=0`
  - `last_cycles_o=0`
  - state IDLE
- Push at cycle t on an empty FIFO: `pending_o=1` at t+1, state ISSUE at t+2, `core_cfg_valid_o=1` at t+2.
- Accept at cycle a: RUN from a+1. Earliest completion is at a+2, giving `last_cycles_o=2`.
- Back-to-back jobs: a completion edge with a non-empty FIFO gives ISSUE on the next cycle, with no IDLE bubble.
- All outputs are registered or decoded directly from state/FIFO registers. There is no combinational path from `core_cfg_ready_i` or `core_busy_i` to any output.

## Configuration
- `SNAX_SIMBACORE_LAUNCH_PERF_EN`
  - Defined: the cycle counter and `last_cycles_o` are implemented as described above.
  - Undefined: the counter is not instantiated and `last_cycles_o` is tied to 0. All other behaviour is identical.

## Structure
- Package `snax_simbacore_launch_pkg` holds:
  - the `launch_state_e` enum (IDLE, ISSUE, RUN);
  - a `simbacore_cfg_t` packed struct (mode, seq_len, d_model, dt_rank, d_inner, d_final);
  - word-index constants.
- Sub-module `snax_simbacore_cfg_fifo`: parametric register FIFO storing `simbacore_cfg_t`, with full/empty flags and occupancy output.
- The top module contains the FSM, counters and mode masking.

## Test plan
- **Single job:** push mode=0x1FFF|0xE000 in word0 with seqLen=16; core ready immediately, busy high for 5 cycles after accept → `core_cfg_o` word0=0x1FFF, `jobs_done_o=1`, `last_cycles_o=6`, `busy_o=0` afterwards.
- **Backpressure:** hold `core_cfg_ready_i=0` for 10 cycles → `core_cfg_valid_o` stays 1 with stable data; state remains ISSUE; `pending_o=1`.
- **FIFO full:** QueueDepth=2, three pushes while the first job runs → `cfg_ready_o=0` after two pending entries. The third push is held until the first pop, then accepted. Jobs are issued in push order, and `jobs_done_o` ends at 3.
- **Back-to-back:** two queued jobs → the second `core_cfg_valid_o` rises the cycle after the first completion, with no IDLE cycle.
- **Saturation / PERF off:** force a busy period of 2^32+5 cycles (or preload the counter) → `last_cycles_o=0xFFFFFFFF`. With the macro undefined, the same job gives `last_cycles_o=0`.
- **Async reset mid-RUN:** assert `rst_i` between clock edges → all outputs reach reset values immediately, FIFO is empty, `jobs_done_o=0`.
